// File: rtl/wb_ext_arbiter_pkg.sv
// Shared constants and types for the external Wishbone arbiter.
// Cycle-type encodings and the arbiter state enum live here.
package wb_ext_arbiter_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_ext_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester strictly after
// the one-hot 'last' position, wrapping around; a zero 'last' favours bit 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);

    localparam logic [N-1:0] ONE = N'(1'b1);

    logic [N-1:0] mask_hi_s;
    logic [N-1:0] req_hi_s;

    // Positions above 'last' get first pick; otherwise wrap to the lowest requester.
    assign mask_hi_s = ~(last | (last - ONE));
    assign req_hi_s  = req & mask_hi_s;
    assign gnt       = (|req_hi_s) ? (req_hi_s & (~req_hi_s + ONE))
                                   : (req & (~req + ONE));

endmodule

// File: rtl/wb_ext_arbiter.sv
// Round-robin arbiter of the tile master ports onto one external Wishbone slave,
// holding the grant for a whole bus cycle and aborting hung transfers with err.
module wb_ext_arbiter
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS-1:0]               m_cab_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]             m_bte_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_rty_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_o,
    output logic [ADDR_WIDTH-1:0]                s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic [DATA_WIDTH/8-1:0]              s_sel_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic                                 s_cab_o,
    output logic [2:0]                           s_cti_o,
    output logic [1:0]                           s_bte_o,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_rty_i,
    input  logic                                 s_err_i,
    output logic [NUM_MASTERS-1:0]               grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);
    localparam logic [NUM_MASTERS-1:0] LAST_RESET = {1'b1, {(NUM_MASTERS-1){1'b0}}};

    arb_state_e               state_r;
    logic [NUM_MASTERS-1:0]   grant_r;
    logic [NUM_MASTERS-1:0]   last_r;
    logic [NUM_MASTERS-1:0]   win_s;
    logic [WD_W-1:0]          wd_cnt_r;

    logic [ADDR_WIDTH-1:0]    g_adr_s;
    logic [DATA_WIDTH-1:0]    g_dat_s;
    logic [SEL_WIDTH-1:0]     g_sel_s;
    logic                     g_cyc_s;
    logic                     g_stb_s;
    logic                     g_we_s;
    logic                     g_cab_s;
    logic [2:0]               g_cti_s;
    logic [1:0]               g_bte_s;

    logic                     in_grant_s;
    logic                     term_s;
    logic                     timeout_s;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req  (m_cyc_i),
        .last (last_r),
        .gnt  (win_s)
    );

    // AND-OR select of the granted master's request; all zero when nothing is granted.
    always_comb begin
        g_adr_s = '0;
        g_dat_s = '0;
        g_sel_s = '0;
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        g_we_s  = 1'b0;
        g_cab_s = 1'b0;
        g_cti_s = '0;
        g_bte_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            g_adr_s = g_adr_s | (m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_r[i]}});
            g_dat_s = g_dat_s | (m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_r[i]}});
            g_sel_s = g_sel_s | (m_sel_i[i*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{grant_r[i]}});
            g_cyc_s = g_cyc_s | (m_cyc_i[i] & grant_r[i]);
            g_stb_s = g_stb_s | (m_stb_i[i] & grant_r[i]);
            g_we_s  = g_we_s  | (m_we_i[i]  & grant_r[i]);
            g_cab_s = g_cab_s | (m_cab_i[i] & grant_r[i]);
            g_cti_s = g_cti_s | (m_cti_i[i*3 +: 3] & {3{grant_r[i]}});
            g_bte_s = g_bte_s | (m_bte_i[i*2 +: 2] & {2{grant_r[i]}});
        end
    end

    assign in_grant_s = (state_r == ST_GRANT);
    assign term_s     = s_ack_i | s_rty_i | s_err_i;
    // A real slave termination in the last watchdog cycle takes precedence over the abort.
    assign timeout_s  = (TIMEOUT != 0) && in_grant_s && g_cyc_s && g_stb_s && !term_s
                        && (wd_cnt_r == WD_LAST);

    assign s_adr_o = g_adr_s;
    assign s_dat_o = g_dat_s;
    assign s_sel_o = g_sel_s;
    assign s_we_o  = g_we_s;
    assign s_cab_o = g_cab_s;
    assign s_cti_o = g_cti_s;
    assign s_bte_o = g_bte_s;
    assign s_cyc_o = g_cyc_s & ~timeout_s;
    assign s_stb_o = g_cyc_s & g_stb_s & ~timeout_s;

    assign m_ack_o = grant_r & {NUM_MASTERS{s_ack_i & in_grant_s}};
    assign m_rty_o = grant_r & {NUM_MASTERS{s_rty_i & in_grant_s}};
    assign m_err_o = grant_r & {NUM_MASTERS{(s_err_i | timeout_s) & in_grant_s}};
    assign m_dat_o = {NUM_MASTERS{s_dat_i}};
    assign grant_o = grant_r;

    // Arbitration FSM with grant hold and per-transfer watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            last_r   <= LAST_RESET;
            wd_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wd_cnt_r <= '0;
                    if (|m_cyc_i) begin
                        grant_r <= win_s;
                        last_r  <= win_s;
                        state_r <= ST_GRANT;
                    end else begin
                        grant_r <= '0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!g_cyc_s) begin
                        state_r  <= ST_IDLE;
                        grant_r  <= '0;
                        wd_cnt_r <= '0;
                    end else if (term_s || timeout_s) begin
                        wd_cnt_r <= '0;
                    end else if (g_stb_s) begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= '0;
                    wd_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Self-checking bench for wb_ext_arbiter: picker vector table, directed corner
// sequences and a randomized run, all compared against a cycle model every cycle.
module tb_wb_ext_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            cyc [NM];
    logic            stb [NM];
    logic            we  [NM];
    logic            cab [NM];
    logic [AW-1:0]   adr [NM];
    logic [DW-1:0]   dat [NM];
    logic [3:0]      sel [NM];
    logic [2:0]      cti [NM];
    logic [1:0]      bte [NM];

    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [NM*3-1:0]  m_cti_i;
    logic [NM*2-1:0]  m_bte_i;
    logic [NM-1:0]    m_ack_o, m_rty_o, m_err_o;
    logic [NM*DW-1:0] m_dat_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_cyc_o, s_stb_o, s_we_o, s_cab_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i, s_rty_i, s_err_i;
    logic [NM-1:0]    grant_o;

    for (genvar g = 0; g < NM; g++) begin : g_pack
        assign m_adr_i[g*AW +: AW] = adr[g];
        assign m_dat_i[g*DW +: DW] = dat[g];
        assign m_sel_i[g*4 +: 4]   = sel[g];
        assign m_cti_i[g*3 +: 3]   = cti[g];
        assign m_bte_i[g*2 +: 2]   = bte[g];
        assign m_cyc_i[g] = cyc[g];
        assign m_stb_i[g] = stb[g];
        assign m_we_i[g]  = we[g];
        assign m_cab_i[g] = cab[g];
    end

    wb_ext_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_cab_i(m_cab_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_ack_o(m_ack_o), .m_rty_o(m_rty_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_rty_i(s_rty_i),
        .s_err_i(s_err_i), .grant_o(grant_o)
    );

    logic [NM-1:0] rr_req, rr_last, rr_gnt;
    rr_arbiter #(.N(NM)) u_rr (.req(rr_req), .last(rr_last), .gnt(rr_gnt));

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
    } rr_vec_t;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Reference model state: owner index (-1 when idle), last winner, watchdog count.
    int md_owner = -1;
    int md_last  = NM - 1;
    int md_wd    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < NM; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; cab[i] = 1'b0;
            adr[i] = '0; dat[i] = '0; sel[i] = '0; cti[i] = '0; bte[i] = '0;
        end
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 16 && idx < 0; n++) begin
            if (grant_o != 4'b0000) begin
                for (int i = 0; i < NM; i++) if (grant_o[i]) idx = i;
            end else begin
                next();
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: no grant within 16 cycles at %0t", $time);
            idx = 0;
        end
    endtask

    // Expected outputs from the current owner and inputs, then advance the model one cycle.
    task automatic model_step();
        logic [3:0] eg, ea, er, ee, e_sel;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic e_cyc, e_stb, e_we, e_cab, gc, gs, term, to;
        logic [2:0] e_cti;
        logic [1:0] e_bte;
        int g;
        g = md_owner;
        term = s_ack_i | s_rty_i | s_err_i;
        eg = '0; ea = '0; er = '0; ee = '0; e_sel = '0; e_adr = '0; e_dat = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_cab = 1'b0; e_cti = '0; e_bte = '0;
        gc = 1'b0; gs = 1'b0; to = 1'b0;
        if (g >= 0) begin
            gc = cyc[g];
            gs = stb[g];
            to = gc && gs && !term && (md_wd == TMO - 1);
            eg[g] = 1'b1; ea[g] = s_ack_i; er[g] = s_rty_i; ee[g] = s_err_i | to;
            e_adr = adr[g]; e_dat = dat[g]; e_sel = sel[g]; e_we = we[g]; e_cab = cab[g];
            e_cti = cti[g]; e_bte = bte[g];
            e_cyc = gc && !to;
            e_stb = gc && gs && !to;
        end
        chk("grant_o", grant_o, eg);
        chk("s_cyc_o", s_cyc_o, e_cyc);
        chk("s_stb_o", s_stb_o, e_stb);
        chk("s_adr_o", s_adr_o, e_adr);
        chk("s_dat_o", s_dat_o, e_dat);
        chk("s_sel_o", s_sel_o, e_sel);
        chk("s_we_o", s_we_o, e_we);
        chk("s_cab_o", s_cab_o, e_cab);
        chk("s_cti_o", s_cti_o, e_cti);
        chk("s_bte_o", s_bte_o, e_bte);
        chk("m_ack_o", m_ack_o, ea);
        chk("m_rty_o", m_rty_o, er);
        chk("m_err_o", m_err_o, ee);
        chk("m_dat_o", m_dat_o, {4{s_dat_i}});
        if (rst) begin
            md_owner = -1; md_last = NM - 1; md_wd = 0;
        end else if (g < 0) begin
            for (int k = 1; k <= NM; k++)
                if (md_owner < 0 && cyc[(md_last + k) % NM]) md_owner = (md_last + k) % NM;
            if (md_owner >= 0) md_last = md_owner;
            md_wd = 0;
        end else if (!gc) begin
            md_owner = -1; md_wd = 0;
        end else if (term || to) begin
            md_wd = 0;
        end else if (gs) begin
            md_wd = md_wd + 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) model_step();
    end

    initial begin
        rr_vec_t vecs [9];
        int exp_order [5];
        int idx;
        logic [3:0] oh;

        vecs[0] = '{req: 4'b0000, last: 4'b1000, gnt: 4'b0000};
        vecs[1] = '{req: 4'b1111, last: 4'b1000, gnt: 4'b0001};
        vecs[2] = '{req: 4'b1111, last: 4'b0001, gnt: 4'b0010};
        vecs[3] = '{req: 4'b1111, last: 4'b0100, gnt: 4'b1000};
        vecs[4] = '{req: 4'b0001, last: 4'b0001, gnt: 4'b0001};
        vecs[5] = '{req: 4'b0101, last: 4'b0010, gnt: 4'b0100};
        vecs[6] = '{req: 4'b0011, last: 4'b1000, gnt: 4'b0001};
        vecs[7] = '{req: 4'b1010, last: 4'b0010, gnt: 4'b1000};
        vecs[8] = '{req: 4'b0110, last: 4'b0100, gnt: 4'b0010};
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        clear_masters();
        s_dat_i = '0; s_ack_i = 1'b0; s_rty_i = 1'b0; s_err_i = 1'b0;

        for (int v = 0; v < 9; v++) begin
            rr_req = vecs[v].req;
            rr_last = vecs[v].last;
            #1;
            chk("rr_gnt", rr_gnt, vecs[v].gnt);
        end

        next();
        chk_en = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("reset grant", grant_o, 4'b0000);
        chk("reset s_cyc", s_cyc_o, 1'b0);

        // Single master read
        next();
        cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 32'h0000_1000; sel[2] = 4'hF;
        @(negedge clk);
        chk("A arb latency", grant_o, 4'b0000);
        next();
        @(negedge clk);
        chk("A grant", grant_o, 4'b0100);
        chk("A s_adr", s_adr_o, 32'h0000_1000);
        next(); next(); next();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("A ack", m_ack_o, 4'b0100);
        chk("A rdata", m_dat_o[95:64], 32'hDEAD_BEEF);
        next();
        s_ack_i = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        chk("A release s_cyc", s_cyc_o, 1'b0);
        chk("A single ack", m_ack_o, 4'b0000);
        next();
        @(negedge clk);
        chk("A idle", grant_o, 4'b0000);

        // Contention right after reset
        next(); rst = 1'b1;
        next(); rst = 1'b0;
        for (int i = 0; i < NM; i++) begin
            cyc[i] = 1'b1; stb[i] = 1'b1; adr[i] = 32'h100 * i; dat[i] = 32'hA000 + i;
        end
        for (int n = 0; n < 5; n++) begin
            wait_grant(idx);
            chk("C order", idx, exp_order[n]);
            oh = 4'b0001 << idx;
            s_ack_i = 1'b1;
            @(negedge clk);
            chk("C ack", m_ack_o, oh);
            next();
            s_ack_i = 1'b0; cyc[idx] = 1'b0; stb[idx] = 1'b0;
            @(negedge clk);
            chk("C hold at release", grant_o, oh);
            chk("C release s_cyc", s_cyc_o, 1'b0);
            next();
            if (n == 0) begin
                cyc[0] = 1'b1; stb[0] = 1'b1;
            end
            @(negedge clk);
            chk("C idle gap", grant_o, 4'b0000);
        end

        // Burst hold: m1 bursts while m0 waits
        next();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010;
        wait_grant(idx);
        chk("B first grant", idx, 1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("B hold wait", grant_o, 4'b0010);
            next();
            cti[1] = (b == 3) ? 3'b111 : 3'b010;
            s_ack_i = 1'b1;
            @(negedge clk);
            chk("B beat ack", m_ack_o, 4'b0010);
            chk("B hold beat", grant_o, 4'b0010);
            next();
            s_ack_i = 1'b0;
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; cti[1] = 3'b000;
        @(negedge clk);
        chk("B hold at drop", grant_o, 4'b0010);
        next();
        @(negedge clk);
        chk("B idle", grant_o, 4'b0000);
        next();
        @(negedge clk);
        chk("B m0 after burst", grant_o, 4'b0001);
        next();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        next(); next();

        // Watchdog on m3
        cyc[3] = 1'b1; stb[3] = 1'b1;
        wait_grant(idx);
        chk("W grant", idx, 3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("W err", m_err_o, (k == TMO) ? 4'b1000 : 4'b0000);
            chk("W s_stb", s_stb_o, (k == TMO) ? 1'b0 : 1'b1);
            next();
        end
        cyc[3] = 1'b0; stb[3] = 1'b0;
        @(negedge clk);
        chk("W grant kept", grant_o, 4'b1000);
        next();
        @(negedge clk);
        chk("W released", grant_o, 4'b0000);

        // Ack in the timeout cycle, then err/rty forwarding
        next();
        cyc[1] = 1'b1; stb[1] = 1'b1;
        wait_grant(idx);
        chk("R grant", idx, 1);
        for (int k = 1; k < TMO; k++) next();
        s_ack_i = 1'b1;
        @(negedge clk);
        chk("R ack wins", m_ack_o, 4'b0010);
        chk("R no err", m_err_o, 4'b0000);
        next();
        s_ack_i = 1'b0; s_err_i = 1'b1;
        @(negedge clk);
        chk("R err fwd", m_err_o, 4'b0010);
        next();
        s_err_i = 1'b0; s_rty_i = 1'b1;
        @(negedge clk);
        chk("R rty fwd", m_rty_o, 4'b0010);
        next();
        s_rty_i = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        next(); next();

        // Reset in the middle of m2's burst
        cyc[2] = 1'b1; stb[2] = 1'b1; cti[2] = 3'b010;
        wait_grant(idx);
        chk("X grant", idx, 2);
        s_ack_i = 1'b1;
        @(negedge clk);
        chk("X beat ack", m_ack_o, 4'b0100);
        next();
        cyc[0] = 1'b1; stb[0] = 1'b1; rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("X grant cleared", grant_o, 4'b0000);
        chk("X s_cyc cleared", s_cyc_o, 1'b0);
        chk("X no ack", m_ack_o, 4'b0000);
        next();
        @(negedge clk);
        chk("X m0 first", grant_o, 4'b0001);
        next();
        s_ack_i = 1'b0;
        clear_masters();
        next(); next();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 5) == 0) cyc[i] = ~cyc[i];
                stb[i] = cyc[i] & ($urandom_range(0, 3) != 0);
                we[i]  = 1'($urandom_range(0, 1));
                cab[i] = 1'($urandom_range(0, 1));
                adr[i] = $urandom;
                dat[i] = $urandom;
                sel[i] = 4'($urandom_range(0, 15));
                cti[i] = 3'($urandom_range(0, 7));
                bte[i] = 2'($urandom_range(0, 3));
            end
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(0, 3) == 0);
            s_err_i = ($urandom_range(0, 15) == 0);
            s_rty_i = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            next();
        end

        rst = 1'b0;
        clear_masters();
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        next(); next(); next();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ext_arbiter.md
Name: wb_ext_arbiter

Overview:
- Downstream consumer of the per-tile external Wishbone master ports of the 2x2 distributed-memory compute-tile system.
- Arbitrates the NUM_MASTERS packed master buses onto one shared external Wishbone slave, such as a memory controller or peripheral bridge.
- Round-robin arbitration; grant is held for the whole bus cycle.
- Includes a per-transfer watchdog that terminates hung transfers with an error.

Parameters:
- NUM_MASTERS, 4, number of tile master ports; packed-bus multiplier.
- ADDR_WIDTH, 32, address width per master.
- DATA_WIDTH, 32, data width per master; SEL width = DATA_WIDTH/8.
- TIMEOUT, 255, cycles without termination before the watchdog error; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses; slice i = [(i+1)*ADDR_WIDTH-1:i*ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects
- m_cyc_i, m_stb_i, m_we_i, m_cab_i  in  NUM_MASTERS  per-master control
- m_cti_i  in  NUM_MASTERS*3  cycle type
- m_bte_i  in  NUM_MASTERS*2  burst type
- m_ack_o, m_rty_o, m_err_o  out  NUM_MASTERS  per-master termination
- m_dat_o  out  NUM_MASTERS*DATA_WIDTH  read data; every slice carries s_dat_i
- s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_cti_o, s_bte_o  out  slave-side widths  forwarded master request
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i, s_rty_i, s_err_i  in  1  slave termination
- grant_o  out  NUM_MASTERS  one-hot current grant (0 when idle)

Behaviour:
- State IDLE:
  - All s_* outputs are 0; all m_ack/m_rty/m_err are 0.
  - If any m_cyc_i is set, select the first requester searching from (last+1) mod NUM_MASTERS.
  - Register grant and last := winner; go to GRANT next cycle. Arbitration latency is 1 cycle.
- State GRANT:
  - s_* = granted master's slices, driven combinationally.
  - s_ack_i/s_rty_i/s_err_i are routed only to the granted master; all other masters see 0.
  - Non-granted masters stall with cyc/stb held.
- Release: when the granted master's m_cyc_i is low, go to IDLE the same cycle, with s_cyc_o=0 that cycle.
  - Re-arbitration takes one more cycle.
  - The grant is never pre-empted while cyc is held, including CTI 010 bursts up to the 111 end.
- Watchdog:
  - wd_cnt clears on entering GRANT and on any slave termination.
  - It increments each cycle while s_stb_o=1 and no termination occurs.
  - When wd_cnt == TIMEOUT-1 and no termination in the same cycle:
    - pulse m_err_o[grant] for 1 cycle;
    - force s_cyc_o=s_stb_o=0 that cycle;
    - clear wd_cnt.
  - The grant is kept until the master drops cyc.
- Simultaneous events:
  - A slave termination in the timeout cycle wins; no err is injected.
  - cyc drop and a termination in the same cycle: the termination is forwarded, then release.
- Reset, including mid-transfer: state=IDLE, grant_o=0, last=NUM_MASTERS-1 (master 0 wins first), wd_cnt=0, all outputs 0 in the cycle after rst is sampled high.
- m_dat_o: s_dat_i replicated to all slices; validity is qualified only by m_ack_o.

Decomposition:
- Shared package constants:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111;
  - the state enum type for IDLE/GRANT.
- Sub-module rr_arbiter: parameter N; inputs req[N], last[N] one-hot; output gnt[N] one-hot. Purely combinational priority rotation, reusable and tested standalone.

Test Plan:
- Single master: m2 reads 0x0000_1000, slave acks after 3 cycles with 0xDEADBEEF.
  - grant_o=0100 one cycle after cyc.
  - m_ack_o[2] pulses once with m_dat_o slice 2 = 0xDEADBEEF; other acks stay 0.
- Contention after reset: m0..m3 all request simultaneously, each holds 1 ack then drops.
  - Grant order 0,1,2,3, then 0 again.
  - One idle cycle between grants.
- Burst hold: m1 issues a 4-beat CTI 010/010/010/111 burst while m0 requests.
  - m0 is not granted until after m1's 4th ack and cyc drop.
- Watchdog: TIMEOUT=8, slave never acks m3.
  - m_err_o[3] pulses exactly 8 cycles after first s_stb_o.
  - s_stb_o is low in that cycle.
  - Grant is released when m3 drops cyc.
- Race: slave ack in the timeout cycle -> ack forwarded, no err.
  - err/rty from the slave are forwarded unchanged to the granted master only.
- Reset mid-burst: rst asserted during m2's burst -> next cycle grant_o=0, s_cyc_o=0, no m_ack; after release, m0 wins first.
